// File: rtl/ir_remote_ctrl_if.sv
// Frame-receiver to command-controller bundle: decoded NEC frames/repeats in, display-control state out.
// The frame source drives through the master modport; the controller consumes through the slave modport.
interface ir_remote_ctrl_if;
    logic        frameValid;
    logic [31:0] frameData;
    logic        repeatValid;
    logic [3:0]  mode;
    logic        showName;
    logic [7:0]  keyCode;
    logic        keyStrobe;
    logic        cmdErr;
    logic        held;

    modport master (
        output frameValid, frameData, repeatValid,
        input  mode, showName, keyCode, keyStrobe, cmdErr, held
    );

    modport slave (
        input  frameValid, frameData, repeatValid,
        output mode, showName, keyCode, keyStrobe, cmdErr, held
    );
endinterface

// File: rtl/ir_remote_ctrl.sv
// NEC command controller: validates frames, steps mode/showName, auto-repeats held CHANNEL+/- keys.
// Latency 1 cycle from input pulse to all outputs; no backpressure, every pulse is consumed the cycle it arrives.
module ir_remote_ctrl #(
    parameter int MODE_MAX     = 10,
    parameter int REPEAT_DELAY = 4,
    parameter int REPEAT_RATE  = 2,
    parameter int HOLD_TIMEOUT = 6000000
) (
    input  logic             clk,
    input  logic             rst,
    ir_remote_ctrl_if.slave  bus
);
    localparam int              TO_W      = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(HOLD_TIMEOUT - 1);
    localparam logic [3:0]      MMAX      = 4'(MODE_MAX);
    localparam logic [8:0]      DELAY9    = 9'(REPEAT_DELAY);
    localparam logic [8:0]      RATE9     = 9'(REPEAT_RATE);
    localparam logic [7:0]      CMD_CH_DN = 8'hA2;
    localparam logic [7:0]      CMD_CH    = 8'h62;
    localparam logic [7:0]      CMD_CH_UP = 8'hE2;

    typedef enum logic {IDLE, HELD} state_t;

    state_t          state, state_nxt;
    logic [3:0]      mode_q, mode_nxt;
    logic            show_q, show_nxt;
    logic [7:0]      key_q, key_nxt;
    logic            strobe_q, strobe_nxt;
    logic            err_q, err_nxt;
    logic [7:0]      hcmd_q, hcmd_nxt;
    logic [7:0]      rep_q, rep_nxt;
    logic [7:0]      rate_q, rate_nxt;
    logic [TO_W-1:0] to_q, to_nxt;

    logic            frame_ok;
    logic            auto_cmd;
    logic            exec;
    logic [7:0]      exec_cmd;
    logic [8:0]      rep_inc;
    logic [8:0]      rate_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= '0;
            show_q   <= 1'b0;
            key_q    <= '0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            hcmd_q   <= '0;
            rep_q    <= '0;
            rate_q   <= '0;
            to_q     <= '0;
        end else begin
            state    <= state_nxt;
            mode_q   <= mode_nxt;
            show_q   <= show_nxt;
            key_q    <= key_nxt;
            strobe_q <= strobe_nxt;
            err_q    <= err_nxt;
            hcmd_q   <= hcmd_nxt;
            rep_q    <= rep_nxt;
            rate_q   <= rate_nxt;
            to_q     <= to_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode_q;
        show_nxt   = show_q;
        key_nxt    = key_q;
        strobe_nxt = 1'b0;
        err_nxt    = 1'b0;
        hcmd_nxt   = hcmd_q;
        rep_nxt    = rep_q;
        rate_nxt   = rate_q;
        to_nxt     = to_q;
        exec       = 1'b0;
        exec_cmd   = hcmd_q;
        frame_ok   = (bus.frameData[31:24] == ~bus.frameData[23:16]) &&
                     (bus.frameData[15:8]  == ~bus.frameData[7:0]);
        auto_cmd   = (hcmd_q == CMD_CH_UP) || (hcmd_q == CMD_CH_DN);
        rep_inc    = {1'b0, rep_q} + 9'd1;
        rate_inc   = {1'b0, rate_q} + 9'd1;

        // A frame always wins over a repeat code arriving in the same cycle.
        if (bus.frameValid) begin
            if (frame_ok) begin
                exec      = 1'b1;
                exec_cmd  = bus.frameData[15:8];
                state_nxt = HELD;
                hcmd_nxt  = bus.frameData[15:8];
                rep_nxt   = '0;
                rate_nxt  = '0;
                to_nxt    = TO_LOAD;
            end else begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
            end
        end else if (state == HELD) begin
            if (bus.repeatValid) begin
                to_nxt  = TO_LOAD;
                rep_nxt = rep_inc[8] ? rep_q : rep_inc[7:0];
                // Once the count has passed the delay it stays there (saturation included), so the rate counter keeps pacing.
                if (auto_cmd) begin
                    if (rep_inc == DELAY9) begin
                        exec     = 1'b1;
                        rate_nxt = '0;
                    end else if ({1'b0, rep_q} >= DELAY9) begin
                        if (rate_inc == RATE9) begin
                            exec     = 1'b1;
                            rate_nxt = '0;
                        end else begin
                            rate_nxt = rate_inc[7:0];
                        end
                    end
                end
            end else if (to_q == '0) begin
                state_nxt = IDLE;
            end else begin
                to_nxt = to_q - TO_W'(1);
            end
        end

        if (exec) begin
            key_nxt    = exec_cmd;
            strobe_nxt = 1'b1;
            case (exec_cmd)
                CMD_CH_UP: mode_nxt = (mode_q == MMAX) ? 4'd0 : mode_q + 4'd1;
                CMD_CH_DN: mode_nxt = (mode_q == 4'd0) ? MMAX : mode_q - 4'd1;
                CMD_CH:    show_nxt = ~show_q;
                default:   ;
            endcase
        end
    end

    assign bus.mode      = mode_q;
    assign bus.showName  = show_q;
    assign bus.keyCode   = key_q;
    assign bus.keyStrobe = strobe_q;
    assign bus.cmdErr    = err_q;
    assign bus.held      = (state == HELD);
endmodule

// File: tb/tb_ir_remote_ctrl.sv
// Scoreboarded bench for ir_remote_ctrl: directed scenarios then random frames/repeats/resets,
// checked against a cycle-count reference model of the command rules.
module tb_ir_remote_ctrl;
    localparam int MMAX = 10;
    localparam int DLY  = 4;
    localparam int RATE = 2;
    localparam int TMO  = 300;

    typedef struct packed {
        logic       held;
        logic [3:0] mode;
        logic       show;
        logic [7:0] key;
        logic       strobe;
        logic       err;
    } st_t;

    typedef struct packed {
        logic       err;
        logic [7:0] key;
        logic [3:0] mode;
        logic       show;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ir_remote_ctrl_if bus();

    ir_remote_ctrl #(
        .MODE_MAX(MMAX), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .HOLD_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    st_t stq[$];
    ev_t evq[$];
    int  vectors     = 0;
    int  miscompares = 0;

    // Reference model: plain integers, repeat count unbounded, timeout as cycles of silence.
    int         m_mode  = 0;
    bit         m_show  = 1'b0;
    logic [7:0] m_key   = 8'h00;
    bit         m_held  = 1'b0;
    int         m_n     = 0;
    int         m_quiet = 0;
    logic [7:0] m_hcmd  = 8'h00;

    task automatic apply(input bit r, input bit fv, input logic [31:0] fd, input bit rv);
        bit         ex;
        bit         err;
        logic [7:0] c;
        st_t        s;
        ev_t        e;
        @(negedge clk);
        rst             = r;
        bus.frameValid  = fv;
        bus.frameData   = fd;
        bus.repeatValid = rv;
        ex  = 1'b0;
        err = 1'b0;
        c   = m_hcmd;
        if (r) begin
            m_mode = 0; m_show = 1'b0; m_key = 8'h00; m_held = 1'b0;
            m_n = 0; m_quiet = 0; m_hcmd = 8'h00;
        end else if (fv) begin
            if (fd[31:24] == ~fd[23:16] && fd[15:8] == ~fd[7:0]) begin
                ex = 1'b1; c = fd[15:8];
                m_held = 1'b1; m_hcmd = c; m_n = 0; m_quiet = 0;
            end else begin
                err = 1'b1; m_held = 1'b0;
            end
        end else if (m_held) begin
            if (rv) begin
                m_quiet = 0;
                m_n++;
                if ((m_hcmd == 8'hE2 || m_hcmd == 8'hA2) && m_n >= DLY && ((m_n - DLY) % RATE) == 0)
                    ex = 1'b1;
            end else begin
                m_quiet++;
                if (m_quiet >= TMO) m_held = 1'b0;
            end
        end
        if (ex) begin
            m_key = c;
            if (c == 8'hE2) m_mode = (m_mode + 1) % (MMAX + 1);
            else if (c == 8'hA2) m_mode = (m_mode + MMAX) % (MMAX + 1);
            else if (c == 8'h62) m_show = !m_show;
        end
        s = '{held: m_held, mode: 4'(m_mode), show: m_show, key: m_key, strobe: ex, err: err};
        stq.push_back(s);
        if (ex || err) begin
            e = '{err: err, key: m_key, mode: 4'(m_mode), show: m_show};
            evq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] mkframe(input logic [7:0] a, input logic [7:0] c);
        return {a, ~a, c, ~c};
    endfunction

    // Monitor: per-cycle state check plus event scoreboard popped on each output pulse.
    initial begin
        st_t s;
        st_t a;
        ev_t e;
        ev_t ae;
        forever begin
            @(posedge clk);
            #1;
            if (stq.size() > 0) begin
                s = stq.pop_front();
                a = '{held: bus.held, mode: bus.mode, show: bus.showName, key: bus.keyCode,
                      strobe: bus.keyStrobe, err: bus.cmdErr};
                vectors++;
                if (a !== s) begin
                    miscompares++;
                    $display("FAIL state @%0t: got held=%b mode=%0d show=%b key=%h strobe=%b err=%b, want held=%b mode=%0d show=%b key=%h strobe=%b err=%b",
                             $time, a.held, a.mode, a.show, a.key, a.strobe, a.err,
                             s.held, s.mode, s.show, s.key, s.strobe, s.err);
                end
            end
            if (bus.keyStrobe === 1'b1 || bus.cmdErr === 1'b1) begin
                vectors++;
                ae = '{err: bus.cmdErr, key: bus.keyCode, mode: bus.mode, show: bus.showName};
                if (evq.size() == 0) begin
                    miscompares++;
                    $display("FAIL event @%0t: unexpected pulse strobe=%b err=%b", $time, bus.keyStrobe, bus.cmdErr);
                end else begin
                    e = evq.pop_front();
                    if (ae !== e) begin
                        miscompares++;
                        $display("FAIL event @%0t: got err=%b key=%h mode=%0d show=%b, want err=%b key=%h mode=%0d show=%b",
                                 $time, ae.err, ae.key, ae.mode, ae.show, e.err, e.key, e.mode, e.show);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] fd;
        logic [7:0]  cmd;
        int          sel;
        bus.frameValid  = 1'b0;
        bus.frameData   = 32'h0;
        bus.repeatValid = 1'b0;

        apply(1'b1, 1'b0, 32'h0, 1'b0);
        apply(1'b1, 1'b0, 32'h0, 1'b0);
        idle(2);
        // CHANNEL+ eleven times: walk 1..10 then wrap to 0
        for (int i = 0; i < 11; i++) begin
            apply(1'b0, 1'b1, 32'h00FFE21D, 1'b0);
            idle(1);
        end
        // CHANNEL toggles twice, repeats never retoggle
        apply(1'b0, 1'b1, 32'h00FF629D, 1'b0);
        apply(1'b0, 1'b1, 32'h00FF629D, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, 32'h0, 1'b1);
            idle(3);
        end
        // CHANNEL- from 0 wraps to MAX, then auto-steps at repeats 4, 6, 8
        apply(1'b1, 1'b0, 32'h0, 1'b0);
        apply(1'b0, 1'b1, 32'h00FFA25D, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle(20);
            apply(1'b0, 1'b0, 32'h0, 1'b1);
        end
        // Bad command complement drops the hold; later repeats ignored
        apply(1'b0, 1'b1, 32'h00FFE21C, 1'b0);
        for (int i = 0; i < 6; i++) apply(1'b0, 1'b0, 32'h0, 1'b1);
        // Hold timeout edge, then a stale repeat
        apply(1'b0, 1'b1, 32'h00FFE21D, 1'b0);
        idle(TMO + 5);
        apply(1'b0, 1'b0, 32'h0, 1'b1);
        // Long hold pushes the repeat counter past saturation
        apply(1'b0, 1'b1, 32'h00FFE21D, 1'b0);
        for (int i = 0; i < 300; i++) apply(1'b0, 1'b0, 32'h0, 1'b1);
        idle(2);
        // Frame and repeat together, then reset mid-hold with pulses discarded
        apply(1'b0, 1'b1, 32'h00FFE21D, 1'b1);
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 32'h0, 1'b1);
        apply(1'b1, 1'b1, 32'h00FFE21D, 1'b1);
        idle(3);

        for (int i = 0; i < 15000; i++) begin
            sel = $urandom_range(0, 999);
            if (sel < 2) begin
                apply(1'b1, $urandom_range(0, 1) == 1, 32'h00FFE21D, 1'b0);
            end else if (sel < 5) begin
                idle(TMO + $urandom_range(0, 3) - 2);
            end else if (sel < 40) begin
                case ($urandom_range(0, 5))
                    0, 1:    cmd = 8'hE2;
                    2:       cmd = 8'hA2;
                    3:       cmd = 8'h62;
                    default: cmd = 8'($urandom_range(0, 255));
                endcase
                fd = mkframe(8'($urandom_range(0, 255)), cmd);
                if ($urandom_range(0, 5) == 0) fd = fd ^ (32'h1 << $urandom_range(0, 31));
                apply(1'b0, 1'b1, fd, $urandom_range(0, 7) == 0);
            end else if (sel < 400) begin
                apply(1'b0, 1'b0, 32'h0, 1'b1);
            end else begin
                apply(1'b0, 1'b0, 32'h0, 1'b0);
            end
        end
        idle(3);
        @(posedge clk);
        #2;
        vectors++;
        if (stq.size() != 0 || evq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d state and %0d events left, want 0 and 0", stq.size(), evq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
